imm_decode_stage: RTL and testbench

Parametrised, pipelined immediate-decode stage for the superscalar front end. Each cycle it accepts an issue group of `LANES` instructions with their PCs, decodes each lane's RV32I/RV64I immediate and format, and precomputes the PC-relative target `pc + imm`. Results are registered behind a 2-entry skid buffer with valid/ready handshakes on both sides, so full throughput holds under back-pressure. It sits between fetch/align and the rename/dispatch stage.

---
 rtl/imm_pkg.sv | 89 ++++++++
 rtl/imm_lane_dec.sv | 25 ++
 rtl/imm_decode_stage.sv | 111 +++++++++++
 tb/tb_imm_decode_stage.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imm_pkg.sv
// Immediate formats, RV opcodes and the shared per-instruction immediate decoder.
// Immediates are produced at 64 bits; narrower datapaths keep the low XLEN bits.
package imm_pkg;

   typedef enum logic [2:0] {
      FMT_NONE = 3'd0,
      FMT_I    = 3'd1,
      FMT_S    = 3'd2,
      FMT_B    = 3'd3,
      FMT_U    = 3'd4,
      FMT_J    = 3'd5,
      FMT_SH   = 3'd6
   } imm_fmt_t;

   typedef enum logic [1:0] {
      ST_EMPTY = 2'd0,
      ST_ONE   = 2'd1,
      ST_FULL  = 2'd2
   } skid_state_t;

   localparam logic [6:0] OPC_LOAD      = 7'b0000011;
   localparam logic [6:0] OPC_JALR      = 7'b1100111;
   localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
   localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
   localparam logic [6:0] OPC_STORE     = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
   localparam logic [6:0] OPC_LUI       = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC     = 7'b0010111;
   localparam logic [6:0] OPC_JAL       = 7'b1101111;

   typedef struct packed {
      logic [63:0] imm;
      imm_fmt_t    fmt;
      logic        illegal;
   } imm_dec_t;

   function automatic imm_dec_t imm_decode(input logic [31:0] instr, input logic xlen64);
      imm_dec_t    r;
      logic        is_shift;
      logic [63:0] i_imm;
      logic [63:0] s_imm;
      logic [63:0] b_imm;
      logic [63:0] u_imm;
      logic [63:0] j_imm;
      r.imm     = '0;
      r.fmt     = FMT_NONE;
      r.illegal = 1'b0;
      is_shift  = (instr[13:12] == 2'b01);
      i_imm = {{52{instr[31]}}, instr[31:20]};
      s_imm = {{52{instr[31]}}, instr[31:25], instr[11:7]};
      b_imm = {{52{instr[31]}}, instr[7], instr[30:25], instr[11:8], 1'b0};
      u_imm = {{32{instr[31]}}, instr[31:12], 12'b0};
      j_imm = {{44{instr[31]}}, instr[19:12], instr[20], instr[30:21], 1'b0};
      case (instr[6:0])
         OPC_LOAD, OPC_JALR: begin r.fmt = FMT_I; r.imm = i_imm; end
         OPC_OP_IMM: begin
            if (!is_shift) begin
               r.fmt = FMT_I;
               r.imm = i_imm;
            end else if (xlen64) begin
               r.fmt = FMT_SH;
               r.imm = {58'd0, instr[25:20]};
            end else begin
               r.fmt     = FMT_SH;
               r.imm     = {59'd0, instr[24:20]};
               r.illegal = instr[25];
            end
         end
         // Word-sized shifts always take a 5-bit shamt, even on RV64.
         OPC_OP_IMM_32: begin
            if (xlen64 && is_shift) begin
               r.fmt     = FMT_SH;
               r.imm     = {59'd0, instr[24:20]};
               r.illegal = instr[25];
            end else if (xlen64) begin
               r.fmt = FMT_I;
               r.imm = i_imm;
            end
         end
         OPC_STORE:          begin r.fmt = FMT_S; r.imm = s_imm; end
         OPC_BRANCH:         begin r.fmt = FMT_B; r.imm = b_imm; end
         OPC_LUI, OPC_AUIPC: begin r.fmt = FMT_U; r.imm = u_imm; end
         OPC_JAL:            begin r.fmt = FMT_J; r.imm = j_imm; end
         default:            ;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/imm_lane_dec.sv
// One lane: immediate/format decode plus the PC-relative target adder.
// Purely combinational; feeds the skid buffer registers in the top level.
module imm_lane_dec
   import imm_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   output logic [XLEN-1:0] imm_o,
   output logic [2:0]      fmt_o,
   output logic [XLEN-1:0] target_o,
   output logic            illegal_o
);

   imm_dec_t dec;

   always_comb dec = imm_decode(instr_i, XLEN == 64);

   assign imm_o     = dec.imm[XLEN-1:0];
   assign fmt_o     = dec.fmt;
   assign illegal_o = dec.illegal;
   assign target_o  = pc_i + imm_o;

endmodule

// File: rtl/imm_decode_stage.sv
// Issue-group immediate decode stage: per-lane decoders ahead of a 2-entry skid buffer.
// Outputs always present MAIN; in_ready is registered so out_ready never reaches it combinationally.
module imm_decode_stage
   import imm_pkg::*;
#(
   parameter int LANES = 2,
   parameter int XLEN  = 32
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [LANES-1:0]      in_lane_vld,
   input  logic [LANES*32-1:0]   in_instr,
   input  logic [LANES*XLEN-1:0] in_pc,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [LANES-1:0]      out_lane_vld,
   output logic [LANES*XLEN-1:0] out_imm,
   output logic [LANES*3-1:0]    out_fmt,
   output logic [LANES*XLEN-1:0] out_target,
   output logic [LANES-1:0]      out_illegal
);

   localparam int ENTRY_W = LANES * (2 * XLEN + 5);

   logic [LANES*XLEN-1:0] dec_imm;
   logic [LANES*3-1:0]    dec_fmt;
   logic [LANES*XLEN-1:0] dec_target;
   logic [LANES-1:0]      dec_illegal;
   logic [ENTRY_W-1:0]    dec_entry;

   for (genvar g = 0; g < LANES; g++) begin : g_lane
      imm_lane_dec #(.XLEN(XLEN)) u_dec (
         .instr_i   (in_instr[32*g +: 32]),
         .pc_i      (in_pc[XLEN*g +: XLEN]),
         .imm_o     (dec_imm[XLEN*g +: XLEN]),
         .fmt_o     (dec_fmt[3*g +: 3]),
         .target_o  (dec_target[XLEN*g +: XLEN]),
         .illegal_o (dec_illegal[g])
      );
   end

   assign dec_entry = {in_lane_vld, dec_imm, dec_fmt, dec_target, dec_illegal};

   skid_state_t        state_q, state_d;
   logic [ENTRY_W-1:0] main_q, main_d;
   logic [ENTRY_W-1:0] skid_q, skid_d;
   logic               out_vld_q;
   logic               in_rdy_q;
   logic               accept;
   logic               drain;

   assign accept = in_valid & in_rdy_q;
   assign drain  = out_vld_q & out_ready;

   always_comb begin
      state_d = state_q;
      main_d  = main_q;
      skid_d  = skid_q;
      case (state_q)
         ST_EMPTY: begin
            if (accept) begin
               main_d  = dec_entry;
               state_d = ST_ONE;
            end
         end
         ST_ONE: begin
            if (accept && drain) begin
               main_d = dec_entry;
            end else if (accept) begin
               skid_d  = dec_entry;
               state_d = ST_FULL;
            end else if (drain) begin
               state_d = ST_EMPTY;
            end
         end
         ST_FULL: begin
            if (drain) begin
               main_d  = skid_q;
               state_d = ST_ONE;
            end
         end
         default: state_d = ST_EMPTY;
      endcase
      // A group accepted on the flush edge may have landed in MAIN/SKID; EMPTY hides it.
      if (flush) state_d = ST_EMPTY;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_EMPTY;
         main_q    <= '0;
         skid_q    <= '0;
         out_vld_q <= 1'b0;
         in_rdy_q  <= 1'b1;
      end else begin
         state_q   <= state_d;
         main_q    <= main_d;
         skid_q    <= skid_d;
         out_vld_q <= (state_d != ST_EMPTY);
         in_rdy_q  <= (state_d != ST_FULL);
      end
   end

   assign out_valid = out_vld_q;
   assign in_ready  = in_rdy_q;
   assign {out_lane_vld, out_imm, out_fmt, out_target, out_illegal} = main_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: an XLEN=32 instance against a queue scoreboard, and an
// XLEN=64 instance for RV64-only decode; both LANES=2.
module tb_imm_decode_stage;
   import imm_pkg::*;

   localparam int L = 2;

   logic clk = 1'b0;
   always #5 clk = ~clk;
   logic rst_n;

   logic            a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
   logic [L-1:0]    a_in_lv, a_out_lv, a_out_ill;
   logic [L*32-1:0] a_in_instr, a_in_pc, a_out_imm, a_out_tgt;
   logic [L*3-1:0]  a_out_fmt;

   logic            b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
   logic [L-1:0]    b_in_lv, b_out_lv, b_out_ill;
   logic [L*32-1:0] b_in_instr;
   logic [L*64-1:0] b_in_pc, b_out_imm, b_out_tgt;
   logic [L*3-1:0]  b_out_fmt;

   imm_decode_stage #(.LANES(L), .XLEN(32)) u_a (
      .clk(clk), .rst_n(rst_n), .flush(a_flush), .in_valid(a_in_valid), .in_ready(a_in_ready),
      .in_lane_vld(a_in_lv), .in_instr(a_in_instr), .in_pc(a_in_pc), .out_valid(a_out_valid),
      .out_ready(a_out_ready), .out_lane_vld(a_out_lv), .out_imm(a_out_imm), .out_fmt(a_out_fmt),
      .out_target(a_out_tgt), .out_illegal(a_out_ill));

   imm_decode_stage #(.LANES(L), .XLEN(64)) u_b (
      .clk(clk), .rst_n(rst_n), .flush(b_flush), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_lane_vld(b_in_lv), .in_instr(b_in_instr), .in_pc(b_in_pc), .out_valid(b_out_valid),
      .out_ready(b_out_ready), .out_lane_vld(b_out_lv), .out_imm(b_out_imm), .out_fmt(b_out_fmt),
      .out_target(b_out_tgt), .out_illegal(b_out_ill));

   typedef struct packed {
      logic [L-1:0]       lv;
      logic [L-1:0][63:0] imm;
      logic [L-1:0][2:0]  fmt;
      logic [L-1:0][63:0] tgt;
      logic [L-1:0]       ill;
   } grp_t;

   grp_t q[$];
   int   errors = 0;
   int   checks = 0;
   int   dut_drains = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   // Reference decode from the ISA field layouts, using signed integer arithmetic.
   function automatic void ref_dec(input logic [31:0] ins, input bit x64,
                                   output logic [63:0] imm, output logic [2:0] fmt, output bit ill);
      logic signed [11:0] i12;
      logic signed [12:0] b13;
      logic signed [20:0] j21;
      logic signed [19:0] u20;
      logic [6:0]         opc;
      logic [2:0]         f3;
      opc = ins[6:0];
      f3  = ins[14:12];
      imm = 64'd0;
      fmt = FMT_NONE;
      ill = 1'b0;
      if (opc == 7'h03 || opc == 7'h67) fmt = FMT_I;
      else if (opc == 7'h13 || (x64 && opc == 7'h1B)) fmt = (f3 == 3'd1 || f3 == 3'd5) ? FMT_SH : FMT_I;
      else if (opc == 7'h23) fmt = FMT_S;
      else if (opc == 7'h63) fmt = FMT_B;
      else if (opc == 7'h37 || opc == 7'h17) fmt = FMT_U;
      else if (opc == 7'h6F) fmt = FMT_J;
      case (fmt)
         FMT_I: begin i12 = ins[31:20]; imm = longint'(i12); end
         FMT_S: begin i12 = {ins[31:25], ins[11:7]}; imm = longint'(i12); end
         FMT_B: begin b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; imm = longint'(b13); end
         FMT_U: begin u20 = ins[31:12]; imm = longint'(u20) * 4096; end
         FMT_J: begin j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; imm = longint'(j21); end
         FMT_SH: begin
            if (x64 && opc == 7'h13) imm = 64'(ins[25:20]);
            else begin imm = 64'(ins[24:20]); ill = ins[25]; end
         end
         default: imm = 64'd0;
      endcase
   endfunction

   function automatic grp_t model_grp(input logic [L-1:0] lv, input logic [L*32-1:0] ins,
                                      input logic [L*64-1:0] pc, input bit x64);
      grp_t g;
      logic [63:0] imm;
      logic [2:0]  f;
      bit          il;
      g.lv = lv;
      for (int i = 0; i < L; i++) begin
         ref_dec(ins[32*i +: 32], x64, imm, f, il);
         g.imm[i] = x64 ? imm : {32'd0, imm[31:0]};
         g.fmt[i] = f;
         g.tgt[i] = x64 ? pc[64*i +: 64] + imm : {32'd0, pc[64*i +: 32] + imm[31:0]};
         g.ill[i] = il;
      end
      return g;
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [6:0]  opcs [10] = '{7'h03, 7'h67, 7'h13, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
      logic [31:0] r;
      r = $urandom;
      r[6:0] = opcs[$urandom_range(0, 9)];
      if ($urandom_range(0, 3) == 0) r[13:12] = 2'b01;
      return r;
   endfunction

   function automatic logic [L*64-1:0] a_pc64();
      logic [L*64-1:0] p;
      p = '0;
      for (int i = 0; i < L; i++) p[64*i +: 32] = a_in_pc[32*i +: 32];
      return p;
   endfunction

   task automatic chk_reset_outputs();
      chk("rst_a_out_valid", a_out_valid, 0);
      chk("rst_a_in_ready", a_in_ready, 1);
      chk("rst_a_lane_vld", a_out_lv, 0);
      chk("rst_a_imm", a_out_imm, 0);
      chk("rst_a_target", a_out_tgt, 0);
      chk("rst_a_fmt", a_out_fmt, {FMT_NONE, FMT_NONE});
      chk("rst_a_illegal", a_out_ill, 0);
      chk("rst_b_out_valid", b_out_valid, 0);
      chk("rst_b_in_ready", b_in_ready, 1);
      chk("rst_b_imm", b_out_imm[63:0], 0);
   endtask

   // Called at a falling edge with the A-side inputs for the next rising edge already driven.
   task automatic cycle_a();
      grp_t g;
      bit   acc, drn;
      chk("a_out_valid", a_out_valid, q.size() > 0);
      chk("a_in_ready", a_in_ready, q.size() < 2);
      if (q.size() > 0) begin
         chk("a_lane_vld", a_out_lv, q[0].lv);
         for (int i = 0; i < L; i++) if (q[0].lv[i]) begin
            chk($sformatf("a_imm%0d", i), a_out_imm[32*i +: 32], q[0].imm[i]);
            chk($sformatf("a_fmt%0d", i), a_out_fmt[3*i +: 3], q[0].fmt[i]);
            chk($sformatf("a_tgt%0d", i), a_out_tgt[32*i +: 32], q[0].tgt[i]);
            chk($sformatf("a_ill%0d", i), a_out_ill[i], q[0].ill[i]);
         end
      end
      if (a_out_valid && a_out_ready) dut_drains++;
      acc = a_in_valid && (q.size() < 2);
      drn = (q.size() > 0) && a_out_ready;
      g = model_grp(a_in_lv, a_in_instr, a_pc64(), 1'b0);
      if (a_flush) q.delete();
      else begin
         if (drn) void'(q.pop_front());
         if (acc) q.push_back(g);
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic rand_a_group();
      a_in_lv    = L'($urandom);
      a_in_instr = {rand_instr(), rand_instr()};
      a_in_pc    = {$urandom, $urandom};
   endtask

   // Single RV64 lane-0 group through instance B, returns after it is presented.
   task automatic run_b(input logic [31:0] ins, input logic [63:0] pc);
      b_in_valid = 1'b1;
      b_in_lv    = 2'b01;
      b_in_instr = {32'h00000013, ins};
      b_in_pc    = {64'd0, pc};
      @(posedge clk);
      @(negedge clk);
      b_in_valid = 1'b0;
      chk("b_out_valid", b_out_valid, 1);
   endtask

   initial begin
      grp_t             gb;
      logic [L*32-1:0]  hold_imm;
      logic [L*32-1:0]  bp_instr [4];
      int               idx;

      rst_n = 1'b0;
      a_flush = 1'b0; b_flush = 1'b0; b_out_ready = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         rand_a_group();
         a_in_valid = 1'($urandom); a_out_ready = 1'($urandom);
         b_in_valid = 1'($urandom); b_in_lv = 2'b11;
         b_in_instr = {rand_instr(), rand_instr()}; b_in_pc = {$urandom, $urandom, $urandom, $urandom};
         #1 chk_reset_outputs();
      end
      @(negedge clk);
      a_in_valid = 1'b0; b_in_valid = 1'b0;
      rst_n = 1'b1;

      // Format coverage: accepted on the first edge after reset release.
      a_in_valid = 1'b1; a_in_lv = 2'b11; a_out_ready = 1'b1;
      a_in_instr = {32'hFE000EE3, 32'hFFC50513};
      a_in_pc    = {32'h104, 32'h100};
      cycle_a();
      a_in_valid = 1'b0;
      chk("fmt_out_valid", a_out_valid, 1);
      chk("addi_imm", a_out_imm[31:0], 32'hFFFFFFFC);
      chk("addi_tgt", a_out_tgt[31:0], 32'hFC);
      chk("addi_fmt", a_out_fmt[2:0], FMT_I);
      chk("beq_imm", a_out_imm[63:32], 32'hFFFFFFFC);
      chk("beq_tgt", a_out_tgt[63:32], 32'h100);
      chk("beq_fmt", a_out_fmt[5:3], FMT_B);
      cycle_a();

      // Shifts.
      a_in_valid = 1'b1;
      a_in_instr = {32'h02051513, 32'h40255513};
      a_in_pc    = 64'd0;
      cycle_a();
      a_in_valid = 1'b0;
      chk("srai_imm", a_out_imm[31:0], 2);
      chk("srai_fmt", a_out_fmt[2:0], FMT_SH);
      chk("srai_ill", a_out_ill[0], 0);
      chk("slli32_fmt", a_out_fmt[5:3], FMT_SH);
      chk("slli32_ill", a_out_ill[1], 1);
      cycle_a();
      run_b(32'h02051513, 64'd0);
      chk("slli64_imm", b_out_imm[63:0], 32);
      chk("slli64_ill", b_out_ill[0], 0);
      run_b(32'h0220101B, 64'd0);
      chk("slliw_ill", b_out_ill[0], 1);
      chk("slliw_imm", b_out_imm[63:0], 2);

      // Wrap-around.
      a_in_valid = 1'b1; a_in_lv = 2'b01;
      a_in_instr = {32'h00000013, 32'h0080006F};
      a_in_pc    = {32'h0, 32'hFFFFFFFC};
      cycle_a();
      a_in_valid = 1'b0;
      chk("jal_imm", a_out_imm[31:0], 8);
      chk("jal_wrap_tgt", a_out_tgt[31:0], 32'h4);
      cycle_a();
      run_b(32'h800000B7, 64'h1000);
      chk("lui64_imm", b_out_imm[63:0], 64'hFFFFFFFF80000000);
      chk("lui64_tgt", b_out_tgt[63:0], 64'hFFFFFFFF80001000);
      chk("lui64_fmt", b_out_fmt[2:0], FMT_U);

      // Back-pressure: four groups, out_ready low from the second cycle.
      for (int k = 0; k < 4; k++) bp_instr[k] = {rand_instr(), rand_instr()};
      dut_drains = 0;
      idx = 0;
      a_in_lv = 2'b11;
      for (int c = 0; c < 30 && (idx < 4 || q.size() > 0); c++) begin
         a_out_ready = (c < 1) || (c >= 6);
         a_in_valid  = (idx < 4);
         a_in_instr  = bp_instr[idx % 4];
         a_in_pc     = {32'h2000 + 32'(idx * 8) + 4, 32'h2000 + 32'(idx * 8)};
         if (c == 4) begin
            chk("bp_in_ready_low", a_in_ready, 0);
            hold_imm = a_out_imm;
         end
         if (c == 5) chk("bp_stable_imm", a_out_imm, hold_imm);
         if (a_in_valid && q.size() < 2) idx++;
         cycle_a();
      end
      a_in_valid = 1'b0;
      chk("bp_drains", dut_drains, 4);
      chk("bp_empty", a_out_valid, 0);

      // Flush while FULL with a concurrent input group.
      a_out_ready = 1'b0; a_in_valid = 1'b1;
      rand_a_group(); cycle_a();
      rand_a_group(); cycle_a();
      chk("pre_flush_in_ready", a_in_ready, 0);
      a_flush = 1'b1; rand_a_group(); cycle_a();
      a_flush = 1'b0; a_in_valid = 1'b0;
      chk("flush_out_valid", a_out_valid, 0);
      chk("flush_in_ready", a_in_ready, 1);
      a_out_ready = 1'b1;
      cycle_a(); cycle_a();

      // Flush in ONE with an accept on the same edge: that group is dropped.
      a_in_valid = 1'b1; rand_a_group(); cycle_a();
      a_flush = 1'b1; rand_a_group(); cycle_a();
      a_flush = 1'b0; a_in_valid = 1'b0;
      chk("flush_one_out_valid", a_out_valid, 0);
      cycle_a();

      // Asynchronous reset mid-operation clears outputs without waiting for an edge.
      a_in_valid = 1'b1; a_in_lv = 2'b11;
      a_in_instr = {32'hFFC50513, 32'hFFC50513}; a_in_pc = {32'h40, 32'h40};
      a_out_ready = 1'b0;
      cycle_a();
      a_in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      chk("arst_out_valid", a_out_valid, 0);
      chk("arst_imm", a_out_imm, 0);
      chk("arst_in_ready", a_in_ready, 1);
      q.delete();
      @(negedge clk);
      rst_n = 1'b1;

      // Random traffic on the XLEN=32 instance.
      for (int c = 0; c < 1500; c++) begin
         rand_a_group();
         a_in_valid  = ($urandom_range(0, 3) != 0);
         a_out_ready = ($urandom_range(0, 9) < 7);
         a_flush     = ($urandom_range(0, 40) == 0);
         cycle_a();
      end
      a_flush = 1'b0; a_in_valid = 1'b0; a_out_ready = 1'b1;
      cycle_a(); cycle_a(); cycle_a();

      // Random decode on the XLEN=64 instance at full throughput.
      b_in_valid = 1'b1; b_in_lv = 2'b11; b_out_ready = 1'b1;
      for (int c = 0; c < 300; c++) begin
         b_in_instr = {rand_instr(), rand_instr()};
         b_in_pc    = {$urandom, $urandom, $urandom, $urandom};
         gb = model_grp(b_in_lv, b_in_instr, b_in_pc, 1'b1);
         @(posedge clk);
         @(negedge clk);
         chk("b_rand_valid", b_out_valid, 1);
         for (int i = 0; i < L; i++) begin
            chk($sformatf("b_imm%0d", i), b_out_imm[64*i +: 64], gb.imm[i]);
            chk($sformatf("b_fmt%0d", i), b_out_fmt[3*i +: 3], gb.fmt[i]);
            chk($sformatf("b_tgt%0d", i), b_out_tgt[64*i +: 64], gb.tgt[i]);
            chk($sformatf("b_ill%0d", i), b_out_ill[i], gb.ill[i]);
         end
      end
      b_in_valid = 1'b0;

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
